// File: rtl/alu_issue.sv
// alu_issue: issue stage for a single external RV64I ALU.
// Accepts one decoded instruction, drives the ALU for one cycle (EXEC),
// captures the result/branch decision and holds it until the consumer takes it.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          instruction handshake
//   opcode/funct3/funct7       RV64I fields
//   rs1, rs2, imm, pc          operands, sign-extended immediate, pc
//   alu_a/alu_b/alu_func/alu_sub_sra   ALU drive
//   alu_s/alu_eq/alu_lu/alu_ls         ALU result and compare flags
//   out_valid/out_ready        result handshake
//   out_result/out_br_target/out_br_taken/out_illegal  response fields
module alu_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [63:0] rs1,
  input  logic [63:0] rs2,
  input  logic [63:0] imm,
  input  logic [63:0] pc,
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [2:0]  alu_func,
  output logic        alu_sub_sra,
  input  logic [63:0] alu_s,
  input  logic        alu_eq,
  input  logic        alu_lu,
  input  logic        alu_ls,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result,
  output logic [63:0] out_br_target,
  output logic        out_br_taken,
  output logic        out_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP32   = 7'b0111011;
  localparam logic [6:0] OPC_IMM32  = 7'b0011011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [63:0] rs1;
    logic [63:0] rs2;
    logic [63:0] imm;
    logic [63:0] pc;
  } instr_t;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_t;

  state_t state, state_nxt;
  instr_t h;
  logic   accept;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == S_IDLE) || ((state == S_HOLD) && out_ready);
    accept    = in_valid && in_ready;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC:  state_nxt = S_HOLD;
      S_HOLD:  if (out_ready) state_nxt = accept ? S_EXEC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      h <= '0;
    else if (accept) h <= {opcode, funct3, funct7, rs1, rs2, imm, pc};
  end

  // ---------------- decode (from holding regs only) ----------------
  logic [63:0] d_a, d_b;
  logic [2:0]  d_func;
  logic        d_sub, d_word, d_branch, d_illegal;
  logic        f7_ok, is_reg, is_shift;

  assign f7_ok    = (h.funct7 == 7'b0000000) || (h.funct7 == 7'b0100000);
  assign is_reg   = (h.opcode == OPC_OP) || (h.opcode == OPC_OP32);
  assign is_shift = (h.funct3 == 3'b001) || (h.funct3 == 3'b101);

  always_comb begin
    d_a       = h.rs1;
    d_b       = h.rs2;
    d_func    = h.funct3;
    d_sub     = 1'b0;
    d_word    = 1'b0;
    d_branch  = 1'b0;
    d_illegal = 1'b0;
    case (h.opcode)
      OPC_OP, OPC_IMM: begin
        if (!is_reg) d_b = h.imm;
        if (is_reg && !f7_ok) d_illegal = 1'b1;
        case (h.funct3)
          3'b010, 3'b011: d_sub = 1'b1;              // compare uses subtractor
          3'b000:         d_sub = is_reg & h.funct7[5]; // ADDI has no SUBI
          3'b101:         d_sub = h.funct7[5];
          default:        d_sub = 1'b0;
        endcase
        if (is_shift) d_b[63:6] = '0;
      end
      OPC_OP32, OPC_IMM32: begin
        d_word = 1'b1;
        if (!is_reg) d_b = h.imm;
        if (!((h.funct3 == 3'b000) || is_shift) || (is_reg && !f7_ok))
          d_illegal = 1'b1;
        if (h.funct3 == 3'b000)      d_sub = is_reg & h.funct7[5];
        else if (h.funct3 == 3'b101) d_sub = h.funct7[5];
        // 32-bit right shifts need the upper half prepared so the 64-bit
        // shifter yields the correct low word
        if (h.funct3 == 3'b101)
          d_a = h.funct7[5] ? {{32{h.rs1[31]}}, h.rs1[31:0]} : {32'b0, h.rs1[31:0]};
        if (is_shift) d_b[63:5] = '0;
      end
      OPC_LUI: begin
        d_a    = '0;
        d_b    = h.imm;
        d_func = 3'b000;
      end
      OPC_AUIPC: begin
        d_a    = h.pc;
        d_b    = h.imm;
        d_func = 3'b000;
      end
      OPC_BRANCH: begin
        d_func    = 3'b000;
        d_sub     = 1'b1;
        d_branch  = 1'b1;
        d_illegal = (h.funct3 == 3'b010) || (h.funct3 == 3'b011);
      end
      default: begin
        d_a       = '0;
        d_b       = '0;
        d_func    = 3'b000;
        d_illegal = 1'b1;
      end
    endcase
  end

  logic        taken;
  logic [63:0] result;

  always_comb begin
    case (h.funct3)
      3'b000:  taken = alu_eq;
      3'b001:  taken = !alu_eq;
      3'b100:  taken = alu_ls;
      3'b101:  taken = !alu_ls;
      3'b110:  taken = alu_lu;
      3'b111:  taken = !alu_lu;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    if (d_illegal || d_branch) result = '0;
    else if (d_word)           result = {{32{alu_s[31]}}, alu_s[31:0]};
    else                       result = alu_s;
  end

  // ---------------- ALU drive: live in EXEC, frozen otherwise ----------------
  logic [63:0] a_q, b_q;
  logic [2:0]  func_q;
  logic        sub_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      func_q <= '0;
      sub_q  <= 1'b0;
    end else if (state == S_EXEC) begin
      a_q    <= d_a;
      b_q    <= d_b;
      func_q <= d_func;
      sub_q  <= d_sub;
    end
  end

  assign alu_a       = (state == S_EXEC) ? d_a    : a_q;
  assign alu_b       = (state == S_EXEC) ? d_b    : b_q;
  assign alu_func    = (state == S_EXEC) ? d_func : func_q;
  assign alu_sub_sra = (state == S_EXEC) ? d_sub  : sub_q;

  // ---------------- response registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_br_target <= '0;
      out_br_taken  <= 1'b0;
      out_illegal   <= 1'b0;
    end else if (state == S_EXEC) begin
      out_valid     <= 1'b1;
      out_result    <= result;
      out_br_target <= h.pc + h.imm;
      out_br_taken  <= d_branch && !d_illegal && taken;
      out_illegal   <= d_illegal;
    end else if (out_valid && out_ready) begin
      out_valid     <= 1'b0;
    end
  end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameters: none; data width fixed at 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 in_valid  input  1  decoded instruction offered.
REQ-005 in_ready  output  1  instruction accepted when in_valid && in_ready at a rising edge.
REQ-006 opcode/funct3/funct7  input  7/3/7  RV64I instruction fields.
REQ-007 rs1, rs2, imm, pc  input  64 each  operands, sign-extended immediate, instruction address.
REQ-008 alu_a, alu_b  output  64 each  ALU operands.
REQ-009 alu_func  output  3  ALU select: 000 add, 001 sll, 010 slt, 011 sltu, 100 xor, 101 shift right, 110 or, 111 and.
REQ-010 alu_sub_sra  output  1  ALU subtract / arithmetic-shift enable.
REQ-011 alu_s  input  64  ALU result.
REQ-012 alu_eq, alu_lu, alu_ls  input  1 each  ALU compare flags; valid only while alu_sub_sra=1.
REQ-013 out_valid  output  1  result held.
REQ-014 out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-015 out_result, out_br_target  output  64 each  writeback value; pc+imm.
REQ-016 out_br_taken, out_illegal  output  1 each  branch decision; unsupported encoding.

Function
REQ-017 States IDLE, EXEC, HOLD; IDLE->EXEC on accept; EXEC->HOLD unconditionally; HOLD->IDLE on out_ready without accept; HOLD->EXEC on out_ready with accept.
REQ-018 in_ready = (IDLE) || (HOLD && out_ready); accept registers all instruction inputs into holding registers.
REQ-019 In EXEC, ALU outputs derive combinationally from holding registers only; in IDLE/HOLD, alu_a/alu_b/alu_func/alu_sub_sra hold their last EXEC values (0 after reset).
REQ-020 EXEC edge registers out_result, out_br_taken, out_br_target, out_illegal; out_valid=1 from that edge until handshake. Latency accept->out_valid = 2 edges; throughput 1 per 2 cycles.
REQ-021 Outputs stable while out_valid && !out_ready.
REQ-022 OP (0110011): a=rs1, b=rs2, func=funct3.
REQ-023 OP-IMM (0010011): a=rs1, b=imm, func=funct3.
REQ-024 alu_sub_sra: 1 for funct3 010/011 (comparator needs subtract); funct7[5] for funct3 000 (OP only; OP-IMM forces 0) and 101; else 0.
REQ-025 Shifts (funct3 001/101): b[63:6] forced 0 for 64-bit ops; b[63:5] forced 0 for W ops.
REQ-026 OP-32 (0111011) / OP-IMM-32 (0011011): funct3 000/001/101 only; SRLW a={32'b0,rs1[31:0]}, SRAW a=sign-extend rs1[31:0]; result = sign-extend alu_s[31:0].
REQ-027 LUI (0110111): a=0, b=imm, add; AUIPC (0010111): a=pc, b=imm, add.
REQ-028 BRANCH (1100011): func=000, sub=1, a=rs1, b=rs2; taken by funct3 000 eq, 001 !eq, 100 ls, 101 !ls, 110 lu, 111 !lu; out_result=0.
REQ-029 out_br_target = pc+imm (own adder, wrap mod 2^64) for every instruction; out_br_taken=0 for non-branch.
REQ-030 Illegal: unknown opcode, branch funct3 010/011, W funct3 outside REQ-026, funct7 other than 0000000/0100000 on OP/OP-32 -> out_illegal=1, out_result=0, out_br_taken=0; still one response per accept.
REQ-031 Exactly one out_valid handshake per accepted instruction; none lost or duplicated under any out_ready pattern.

Reset
REQ-032 rst_n low: state IDLE, out_valid=0, all output registers and ALU drive outputs 0, holding registers 0, asynchronously.
REQ-033 Reset mid-EXEC or HOLD discards in-flight instruction; no out_valid after release until a new accept.
REQ-034 in_ready=1 on first edge after rst_n deasserts.

Verification
REQ-035 SUB rs1=5, rs2=7, out_ready=1 -> func=000, sub=1, out_result=0xFFFF_FFFF_FFFF_FFFE two edges after accept.
REQ-036 SRAIW rs1=0x0000_0000_8000_0000, imm=4 -> alu_a=0xFFFF_FFFF_8000_0000, out_result=0xFFFF_FFFF_F800_0000.
REQ-037 BLTU rs1=1, rs2=0xFFFF_FFFF_FFFF_FFFF, pc=0x100, imm=-8 -> out_br_taken=1, out_br_target=0xF8; BLT same operands -> taken=0.
REQ-038 out_ready=0 for 5 cycles with second instruction pending -> in_ready=0, first result stable; out_ready=1 -> handshake and second accepted same edge.
REQ-039 opcode 1111111 -> out_illegal=1, out_result=0, one response; rst_n low during EXEC -> out_valid stays 0.
